// File: rtl/refcpu_pkg.sv
// Shared refcpu definitions: fetch FSM state encoding and the instruction-bus
// request/response bundles used by the fetch unit.
//   fetch_state_e  - fetch controller states
//   ibus_req_t     - request side: valid + address
//   ibus_resp_t    - response side: address accept, data return, read data
//   misaligned()   - true when an instruction address is not word aligned
package refcpu_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_HOLD  = 3'd3,
        FS_DRAIN = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: takes a PC from the control FSM, performs one read
// on the instruction bus and holds the fetched word for decode until consumed.
// At most one bus transaction is ever outstanding; a flush after the address
// has been accepted waits in DRAIN for the orphaned data before going idle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new start request
// REQ   | bus request driven, waiting for address accept
// WAIT  | address accepted, waiting for read data
// HOLD  | fetched word (or address error) presented to decode
// DRAIN | fetch abandoned, swallowing the outstanding read data
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_valid/start_pc       fetch request in, start_ready high in IDLE
//   flush                      abandon current fetch
//   ireq_valid/ireq_addr       bus request out
//   iresp_addr_ok/data_ok/data bus response in
//   out_valid/pc/instr/exc     fetched result to decode, out_ready consumes
module instr_fetch
    import refcpu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    input  logic [31:0] start_pc,
    output logic        start_ready,
    input  logic        flush,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc,
    input  logic        out_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         exc_q, exc_d;
    ibus_resp_t   resp;
    ibus_req_t    req;

    assign resp = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        case (state_q)
            FS_IDLE: begin
                // flush in IDLE blocks a simultaneous start
                if (start_valid && !flush) begin
                    pc_d    = start_pc;
                    instr_d = '0;
                    if (ALIGN_CHECK && misaligned(start_pc)) begin
                        exc_d   = 1'b1;
                        state_d = FS_HOLD;
                    end else begin
                        exc_d   = 1'b0;
                        state_d = FS_REQ;
                    end
                end
            end
            FS_REQ: begin
                // data_ok before the address is accepted is not ours
                if (resp.addr_ok) begin
                    if (resp.data_ok) begin
                        if (flush) begin
                            state_d = FS_IDLE;
                        end else begin
                            instr_d = resp.data;
                            state_d = FS_HOLD;
                        end
                    end else begin
                        state_d = flush ? FS_DRAIN : FS_WAIT;
                    end
                end else if (flush) begin
                    state_d = FS_IDLE;
                end
            end
            FS_WAIT: begin
                if (resp.data_ok) begin
                    if (flush) begin
                        state_d = FS_IDLE;
                    end else begin
                        instr_d = resp.data;
                        state_d = FS_HOLD;
                    end
                end else if (flush) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_HOLD: begin
                if (flush || out_ready) state_d = FS_IDLE;
            end
            FS_DRAIN: begin
                if (resp.data_ok) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    // the request address is the latched PC, so it cannot move during a stall
    assign req.valid = (state_q == FS_REQ);
    assign req.addr  = pc_q;

    assign ireq_valid  = req.valid;
    assign ireq_addr   = req.addr;
    assign start_ready = (state_q == FS_IDLE);
    assign out_valid   = (state_q == FS_HOLD);
    assign out_pc      = pc_q;
    assign out_instr   = instr_q;
    assign out_exc     = exc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Each fetch is described at transaction
// level (PC, data, bus delays, hold time, flush point) and the bench derives
// the expected cycle-by-cycle outputs from those parameters.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic [31:0] start_pc;
    logic        start_ready;
    logic        flush;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_pc     (start_pc),
        .start_ready  (start_ready),
        .flush        (flush),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_exc      (out_exc),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush         = 1'b0;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        out_ready     = 1'b0;
    endtask

    // fl: 0 none, 1 flush in REQ before addr_ok, 2 flush with addr_ok,
    //     3 flush in WAIT without data, 4 flush with data in WAIT, 5 flush in HOLD
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                            input int a_dly, input int d_dly, input int h_dly, input int fl);
        logic        mis;
        logic [31:0] exp_instr;
        mis = (pc[1:0] != 2'b00);
        chk_eq("idle_ready", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        start_pc    = pc;
        tick();
        start_valid = 1'b0;
        start_pc    = $urandom;
        if (!mis) begin
            if (fl == 1 && a_dly == 0) a_dly = 1;
            if ((fl == 2 || fl == 4) && d_dly == 0) d_dly = 1;
            if (fl == 3 && d_dly < 2) d_dly = 2;
            for (int i = 0; i <= a_dly; i++) begin
                chk_eq("req_valid", {31'd0, ireq_valid}, 32'd1);
                chk_eq("req_addr", ireq_addr, pc);
                chk_eq("req_outv", {31'd0, out_valid}, 32'd0);
                chk_eq("req_start_ready", {31'd0, start_ready}, 32'd0);
                if (i < a_dly) begin
                    iresp_data_ok = 1'($urandom_range(0, 1));
                    iresp_data    = $urandom;
                    if (fl == 1 && i == a_dly - 1) begin
                        flush = 1'b1;
                        tick();
                        clear_inputs();
                        chk_eq("flush_req_ivalid", {31'd0, ireq_valid}, 32'd0);
                        chk_eq("flush_req_idle", {31'd0, start_ready}, 32'd1);
                        return;
                    end
                end else begin
                    iresp_addr_ok = 1'b1;
                    iresp_data_ok = (d_dly == 0);
                    iresp_data    = data;
                    flush         = (fl == 2);
                end
                tick();
                clear_inputs();
            end
            if (d_dly > 0) begin
                for (int j = 1; j <= d_dly; j++) begin
                    chk_eq("wait_ivalid", {31'd0, ireq_valid}, 32'd0);
                    chk_eq("wait_outv", {31'd0, out_valid}, 32'd0);
                    chk_eq("wait_start_ready", {31'd0, start_ready}, 32'd0);
                    iresp_data = $urandom;
                    if (j == d_dly) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = data;
                        if (fl == 4) flush = 1'b1;
                    end
                    if (j == 1 && fl == 3) flush = 1'b1;
                    tick();
                    clear_inputs();
                end
                if (fl >= 2 && fl <= 4) begin
                    chk_eq("drain_idle", {31'd0, start_ready}, 32'd1);
                    chk_eq("drain_outv", {31'd0, out_valid}, 32'd0);
                    return;
                end
            end
        end
        exp_instr = mis ? 32'd0 : data;
        for (int k = 0; k <= h_dly; k++) begin
            chk_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            chk_eq("hold_pc", out_pc, pc);
            chk_eq("hold_instr", out_instr, exp_instr);
            chk_eq("hold_exc", {31'd0, out_exc}, {31'd0, mis});
            chk_eq("hold_ivalid", {31'd0, ireq_valid}, 32'd0);
            chk_eq("hold_start_ready", {31'd0, start_ready}, 32'd0);
            iresp_data_ok = 1'($urandom_range(0, 1));
            iresp_data    = $urandom;
            if (k == h_dly) begin
                if (fl == 5) begin
                    flush     = 1'b1;
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = 1'b1;
                end
            end
            tick();
            clear_inputs();
        end
        chk_eq("done_idle", {31'd0, start_ready}, 32'd1);
        chk_eq("done_outv", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_ivalid"}, {31'd0, ireq_valid}, 32'd0);
        chk_eq({tag, "_iaddr"}, ireq_addr, 32'd0);
        chk_eq({tag, "_outv"}, {31'd0, out_valid}, 32'd0);
        chk_eq({tag, "_outpc"}, out_pc, 32'd0);
        chk_eq({tag, "_outinstr"}, out_instr, 32'd0);
        chk_eq({tag, "_outexc"}, {31'd0, out_exc}, 32'd0);
        chk_eq({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] pc;
        reset       = 1'b1;
        start_valid = 1'b0;
        start_pc    = 32'd0;
        iresp_data  = 32'd0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // fastest path, then a stalled bus
        do_fetch(32'hBFC00000, 32'h24080001, 0, 0, 0, 0);
        do_fetch(32'h00001000, 32'h8C220004, 3, 2, 0, 0);
        // misaligned PC never reaches the bus
        do_fetch(32'h00001002, 32'hFFFFFFFF, 0, 0, 0, 0);
        // flush in WAIT, data four cycles later, then a normal fetch
        do_fetch(32'h00002000, 32'hDEADBEEF, 0, 5, 0, 3);
        do_fetch(32'h00002004, 32'h00000000, 1, 1, 0, 0);
        // decode stalls five cycles
        do_fetch(32'h00003000, 32'h3C1D8000, 0, 1, 5, 0);
        // remaining flush points
        do_fetch(32'h00004000, 32'h11111111, 2, 0, 0, 1);
        do_fetch(32'h00004004, 32'h22222222, 0, 3, 0, 2);
        do_fetch(32'h00004008, 32'h33333333, 1, 2, 0, 4);
        do_fetch(32'h0000400C, 32'h44444444, 0, 0, 2, 5);

        // flush in IDLE suppresses a simultaneous start
        start_valid = 1'b1;
        start_pc    = 32'h00005000;
        flush       = 1'b1;
        tick();
        start_valid = 1'b0;
        clear_inputs();
        chk_eq("idle_flush_ready", {31'd0, start_ready}, 32'd1);
        chk_eq("idle_flush_ivalid", {31'd0, ireq_valid}, 32'd0);

        // reset in WAIT
        start_valid = 1'b1;
        start_pc    = 32'h00006000;
        tick();
        start_valid   = 1'b0;
        iresp_addr_ok = 1'b1;
        tick();
        clear_inputs();
        chk_eq("pre_reset_wait", {31'd0, start_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_wait");

        for (int n = 0; n < 60; n++) begin
            pc = $urandom;
            if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
            do_fetch(pc, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ALIGN_CHECK, default 1: when 1, a PC with addr[1:0]!=0 is rejected without a bus access.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port start_valid, input, 1 bit: the control FSM requests a fetch at start_pc.
REQ-005 The block SHALL have port start_pc, input, 32 bits: the fetch address.
REQ-006 The block SHALL have port start_ready, output, 1 bit: high only in IDLE.
REQ-007 The block SHALL have port flush, input, 1 bit: abandon the current fetch.
REQ-008 The block SHALL have port ireq_valid, output, 1 bit: instruction bus request.
REQ-009 The block SHALL have port ireq_addr, output, 32 bits: request address.
REQ-010 The block SHALL have port iresp_addr_ok, input, 1 bit: the bus accepted the address this cycle.
REQ-011 The block SHALL have port iresp_data_ok, input, 1 bit: the bus returns read data this cycle.
REQ-012 The block SHALL have port iresp_data, input, 32 bits: the returned instruction word.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a fetched instruction is presented to decode.
REQ-014 The block SHALL have ports out_pc and out_instr, output, 32 bits each: the fetched PC and instruction word.
REQ-015 The block SHALL have port out_exc, output, 1 bit: fetch address error; out_instr is 0 when set.
REQ-016 The block SHALL have port out_ready, input, 1 bit: decode consumes the output.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and DRAIN.
REQ-018 In IDLE, start_valid SHALL latch start_pc; the next state is REQ, or HOLD with out_exc=1 when ALIGN_CHECK=1 and pc[1:0]!=0.
REQ-019 In REQ, ireq_valid SHALL be 1 with ireq_addr equal to the latched PC, held stable until iresp_addr_ok; iresp_addr_ok moves the FSM to WAIT.
REQ-020 In WAIT, iresp_data_ok SHALL latch iresp_data into out_instr and move the FSM to HOLD.
REQ-021 An address accepted with iresp_addr_ok and iresp_data_ok in the same REQ cycle SHALL go directly to HOLD with the data latched.
REQ-022 In HOLD, out_valid SHALL be 1 and out_pc, out_instr and out_exc SHALL be stable; out_ready moves the FSM to IDLE.
REQ-023 The minimum latency SHALL be 2 cycles from start handshake to out_valid: IDLE to REQ, then REQ to HOLD with same-cycle addr_ok and data_ok.
REQ-024 A flush in REQ before addr_ok SHALL move the FSM to IDLE and drop ireq_valid next cycle.
REQ-025 A flush in REQ coinciding with addr_ok and no data_ok SHALL move the FSM to DRAIN.
REQ-026 A flush in WAIT without data_ok SHALL move the FSM to DRAIN.
REQ-027 A flush in WAIT coinciding with data_ok SHALL move the FSM to IDLE and discard the data.
REQ-028 DRAIN SHALL keep ireq_valid=0 and return to IDLE on iresp_data_ok, discarding the data.
REQ-029 A flush in HOLD SHALL move the FSM to IDLE with no output handshake; flush takes priority over out_ready.
REQ-030 A flush in IDLE SHALL have no effect, and start_valid in the same cycle SHALL be ignored.
REQ-031 There SHALL be at most one outstanding bus transaction; ireq_valid is 0 in every state except REQ.
REQ-032 The block SHALL ignore iresp_data_ok in IDLE, REQ-before-addr_ok and HOLD.

Reset
REQ-033 The reset SHALL put the FSM in IDLE and clear ireq_valid, out_valid, out_exc, out_pc, out_instr and ireq_addr to 0.
REQ-034 A reset asserted mid-transaction SHALL return the block to IDLE without draining; the bus is reset by the same signal.

Structure
REQ-035 The fetch state enum and the ibus request/response structs SHALL live in the shared refcpu definitions package.
REQ-036 The block SHALL have no sub-modules; it is a single FSM plus PC/instruction registers.

Verification
REQ-037 Start pc=0xBFC00000 with addr_ok and data_ok in the first REQ cycle, data=0x24080001 -> out_valid on cycle 2 with out_pc=0xBFC00000 and out_instr=0x24080001.
REQ-038 Start pc=0x1000, addr_ok after 3 cycles, data_ok after 2 more -> ireq_addr stays stable through the stall and out_valid asserts once.
REQ-039 Start pc=0x1002 -> no ireq_valid, HOLD with out_exc=1, out_instr=0.
REQ-040 Flush in WAIT, data_ok 4 cycles later -> DRAIN, the data is discarded, IDLE follows, and the next start fetches normally.
REQ-041 HOLD with out_ready=0 for 5 cycles, then 1 -> outputs stay stable for 5 cycles and start_ready is 1 the next cycle.
REQ-042 Reset asserted in WAIT -> all outputs 0 and IDLE next cycle.
